// File: rtl/score_link_pkg.sv
// Shared definitions for the scoreboard serial link (transmitter and receiver).
package score_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } link_state_t;

  localparam int         FRAME_BITS = 11;
  localparam logic       START_LVL  = 1'b0;
  localparam logic       STOP_LVL   = 1'b1;
  localparam logic       IDLE_LVL   = 1'b1;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  // Even parity over the data byte: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/score_serial_tx_refresh_timer.sv
// Saturating 16-bit idle counter that requests a periodic refresh frame.
module refresh_timer #(
  parameter int unsigned REFRESH_TICKS = 100
) (
  input  logic clk_100Hz,
  input  logic reset,
  input  logic clr,
  input  logic enable,
  output logic hit
);

  // A period of 0 switches refresh off entirely.
  localparam logic        REFRESH_ON = (REFRESH_TICKS != 0);
  localparam logic [15:0] HIT_AT     = (REFRESH_TICKS == 0) ? 16'd0 : 16'(REFRESH_TICKS - 1);

  logic [15:0] count;

  // Count up from the last frame load, holding at the top value.
  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      count <= 16'd0;
    end else if (clr) begin
      count <= 16'd0;
    end else if (enable && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  // Hit stays asserted until the transmitter loads a frame and clears the count.
  assign hit = REFRESH_ON && (count >= HIT_AT);

endmodule

// File: rtl/score_serial_tx.sv
// Sends the two BCD score digits as an 11-bit async frame (start, 8 data LSB first,
// even parity, stop), one bit per tick, on score change, force request or refresh.
//
// Handshake: there is no ready/valid pair on the inputs. A frame is loaded whenever the
// FSM is in IDLE or STOP and a trigger is present with valid digits; triggers that
// cannot be served yet (busy line or invalid digits) are held, never dropped.
module score_serial_tx
  import score_link_pkg::*;
#(
  parameter int unsigned REFRESH_TICKS = 100
) (
  input  logic       clk_100Hz,
  input  logic       reset,
  input  logic [3:0] bcd_hi,
  input  logic [3:0] bcd_low,
  input  logic       force_send,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done,
  output logic       bcd_err,
  output logic [2:0] state_dbg
);

  link_state_t state, state_nxt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_q;
  logic        parity_q;
  logic [7:0]  last_sent;
  logic        force_pend;
  logic        refresh_hit;
  logic        tx_nxt, busy_nxt, done_nxt;

  logic [7:0] score;
  logic       valid, trigger, load;

  assign score   = {bcd_hi, bcd_low};
  assign valid   = (bcd_hi <= BCD_MAX) && (bcd_low <= BCD_MAX);
  assign trigger = (score != last_sent) || force_pend || force_send || refresh_hit;
  // A new frame can only be loaded from IDLE or in the stop-bit slot (back-to-back).
  assign load    = ((state == ST_IDLE) || (state == ST_STOP)) && trigger && valid;

  assign state_dbg = state;

  refresh_timer #(
    .REFRESH_TICKS(REFRESH_TICKS)
  ) u_refresh_timer (
    .clk_100Hz(clk_100Hz),
    .reset    (reset),
    .clr      (load),
    .enable   (1'b1),
    .hit      (refresh_hit)
  );

  // State register.
  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: state names the bit that goes on the line at the next edge.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (load) state_nxt = ST_START;
      ST_START:  state_nxt = ST_DATA;
      ST_DATA:   if (bit_idx == 3'd7) state_nxt = ST_PARITY;
      ST_PARITY: state_nxt = ST_STOP;
      ST_STOP:   state_nxt = load ? ST_START : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: the line level and flags for the bit the current state represents.
  always_comb begin
    tx_nxt   = IDLE_LVL;
    busy_nxt = 1'b1;
    done_nxt = 1'b0;
    case (state)
      ST_IDLE:   busy_nxt = 1'b0;
      ST_START:  tx_nxt   = START_LVL;
      ST_DATA:   tx_nxt   = shift_q[0];
      ST_PARITY: tx_nxt   = parity_q;
      ST_STOP: begin
        tx_nxt   = STOP_LVL;
        done_nxt = 1'b1;
      end
      default:   busy_nxt = 1'b0;
    endcase
  end

  // Registered outputs; reset drives the line back to idle immediately.
  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      tx_out     <= IDLE_LVL;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      tx_out     <= tx_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
      bcd_err    <= ~valid;
    end
  end

  // Frame datapath: capture the score on load, then shift out one data bit per tick.
  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      last_sent  <= 8'h00;
      force_pend <= 1'b0;
      bit_idx    <= 3'd0;
    end else begin
      if (load) begin
        shift_q    <= score;
        parity_q   <= even_parity(score);
        last_sent  <= score;
        force_pend <= 1'b0;
      end else if (force_send) begin
        force_pend <= 1'b1;
      end
      if (state == ST_START) begin
        bit_idx <= 3'd0;
      end
      if (state == ST_DATA) begin
        shift_q <= shift_q >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_score_serial_tx.sv
// Directed bench for score_serial_tx: decodes frames off the line and checks them
// against frames expected from the stimulus; a second instance covers refresh timing.
module tb_score_serial_tx;
  import score_link_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk_100Hz = 1'b0;
  logic       reset;
  logic [3:0] bcd_hi, bcd_low;
  logic       force_send;
  logic       tx_out, busy, frame_done, bcd_err;
  logic [2:0] state_dbg;

  logic [3:0] r_hi  = 4'd9;
  logic [3:0] r_low = 4'd9;
  logic       r_force = 1'b0;
  logic       r_tx, r_busy, r_done, r_err;
  logic [2:0] r_state;

  always #5 clk_100Hz = ~clk_100Hz;

  int cyc = 0;
  always @(posedge clk_100Hz) cyc++;

  score_serial_tx #(.REFRESH_TICKS(0)) dut (
    .clk_100Hz (clk_100Hz),
    .reset     (reset),
    .bcd_hi    (bcd_hi),
    .bcd_low   (bcd_low),
    .force_send(force_send),
    .tx_out    (tx_out),
    .busy      (busy),
    .frame_done(frame_done),
    .bcd_err   (bcd_err),
    .state_dbg (state_dbg)
  );

  score_serial_tx #(.REFRESH_TICKS(20)) dut_r (
    .clk_100Hz (clk_100Hz),
    .reset     (reset),
    .bcd_hi    (r_hi),
    .bcd_low   (r_low),
    .force_send(r_force),
    .tx_out    (r_tx),
    .busy      (r_busy),
    .frame_done(r_done),
    .bcd_err   (r_err),
    .state_dbg (r_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line order: bit 0 is the start bit, bits 1..8 are D0..D7, bit 9 parity, bit 10 stop.
  function automatic logic [10:0] make_frame(input logic [7:0] d);
    return {STOP_LVL, ^d, d, START_LVL};
  endfunction

  // Main line monitor: collect 11 bits per frame, check busy/frame_done on every tick.
  int          m_cnt = 0;
  logic [10:0] m_bits;
  int          frames_seen = 0;
  int          last_start = 0;
  int          prev_start = 0;

  always @(negedge clk_100Hz) begin
    logic in_frame;
    if (reset) begin
      m_cnt = 0;
    end else begin
      in_frame = (m_cnt != 0) || (tx_out == 1'b0);
      chk("busy", 32'(busy), 32'(in_frame));
      chk("frame_done", 32'(frame_done), 32'(in_frame && (m_cnt == FRAME_BITS - 1)));
      if (in_frame) begin
        if (m_cnt == 0) begin
          prev_start = last_start;
          last_start = cyc;
        end
        m_bits[m_cnt] = tx_out;
        m_cnt++;
        if (m_cnt == FRAME_BITS) begin
          frames_seen++;
          chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) chk("frame_bits", 32'(m_bits), 32'(exp_q.pop_front()));
          m_cnt = 0;
        end
      end
    end
  end

  // Refresh-instance monitor: every frame must carry 99; record start cycles.
  int          r_cnt = 0;
  logic [10:0] r_bits;
  int          r_starts[$];

  always @(negedge clk_100Hz) begin
    if (reset) begin
      r_cnt = 0;
    end else if ((r_cnt != 0) || (r_tx == 1'b0)) begin
      if (r_cnt == 0) r_starts.push_back(cyc);
      r_bits[r_cnt] = r_tx;
      r_cnt++;
      if (r_cnt == FRAME_BITS) begin
        chk("refresh_frame", 32'(r_bits), 32'(make_frame(8'h99)));
        r_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_100Hz);
    #1;
  endtask

  task automatic set_score(input logic [3:0] hi, input logic [3:0] lo);
    bcd_hi  = hi;
    bcd_low = lo;
  endtask

  task automatic pulse_force();
    force_send = 1'b1;
    tick(1);
    force_send = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while ((frames_seen < target) && (n < budget)) begin
      tick(1);
      n++;
    end
    chk("frame_wait", 32'(frames_seen >= target), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c0;
    int base;

    reset = 1'b1;
    force_send = 1'b0;
    set_score(4'd0, 4'd0);
    tick(3);
    chk("reset_tx", 32'(tx_out), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(frame_done), 32'd0);
    chk("reset_err", 32'(bcd_err), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b0;

    // Score 00 equals the reset value of last_sent and refresh is off: silence.
    base = frames_seen;
    tick(200);
    chk("idle_no_frame", 32'(frames_seen), 32'(base));
    chk("idle_tx", 32'(tx_out), 32'd1);

    // 00 -> 42: start bit appears two edges after the inputs change.
    set_score(4'd4, 4'd2);
    exp_q.push_back(make_frame(8'h42));
    c0 = cyc;
    wait_frames(base + 1, 40);
    chk("start_latency", 32'(last_start - c0), 32'd2);

    // 07: odd number of ones -> parity bit 1.
    set_score(4'd0, 4'd7);
    exp_q.push_back(make_frame(8'h07));
    wait_frames(base + 2, 40);

    // 42 -> 43 -> 44 inside one frame: only 44 follows, back-to-back.
    set_score(4'd4, 4'd2);
    exp_q.push_back(make_frame(8'h42));
    tick(3);
    set_score(4'd4, 4'd3);
    tick(4);
    set_score(4'd4, 4'd4);
    exp_q.push_back(make_frame(8'h44));
    wait_frames(base + 4, 60);
    chk("back_to_back_gap", 32'(last_start - prev_start), 32'd11);
    tick(30);
    chk("no_extra_after_44", 32'(frames_seen), 32'(base + 4));

    // Invalid units digit: flag after one edge, no frame; force while invalid is held.
    set_score(4'd4, 4'hB);
    chk("err_before_edge", 32'(bcd_err), 32'd0);
    tick(1);
    chk("err_set", 32'(bcd_err), 32'd1);
    pulse_force();
    tick(30);
    chk("invalid_no_frame", 32'(frames_seen), 32'(base + 4));
    chk("err_held", 32'(bcd_err), 32'd1);
    set_score(4'd1, 4'd5);
    exp_q.push_back(make_frame(8'h15));
    tick(1);
    chk("err_clear", 32'(bcd_err), 32'd0);
    wait_frames(base + 5, 40);
    tick(20);
    chk("one_frame_15", 32'(frames_seen), 32'(base + 5));

    // Force while invalid, then back to the already-sent score: held force sends once.
    set_score(4'd1, 4'hB);
    pulse_force();
    tick(10);
    chk("held_no_frame", 32'(frames_seen), 32'(base + 5));
    set_score(4'd1, 4'd5);
    exp_q.push_back(make_frame(8'h15));
    wait_frames(base + 6, 40);
    tick(20);
    chk("held_force_once", 32'(frames_seen), 32'(base + 6));

    // Force pulsed mid-frame: exactly one extra frame.
    set_score(4'd2, 4'd3);
    exp_q.push_back(make_frame(8'h23));
    tick(5);
    pulse_force();
    exp_q.push_back(make_frame(8'h23));
    wait_frames(base + 8, 60);
    tick(30);
    chk("force_one_extra", 32'(frames_seen), 32'(base + 8));

    // Change and force together: a single frame.
    set_score(4'd5, 4'd6);
    pulse_force();
    exp_q.push_back(make_frame(8'h56));
    wait_frames(base + 9, 40);
    tick(30);
    chk("merged_one_frame", 32'(frames_seen), 32'(base + 9));

    // Reset at D3 of a 61 frame: line returns high without waiting for a clock.
    set_score(4'd6, 4'd1);
    exp_q.push_back(make_frame(8'h61));
    tick(6);
    #2;
    chk("d3_level", 32'(tx_out), 32'(make_frame(8'h61) >> 4) & 32'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_tx", 32'(tx_out), 32'd1);
    chk("async_reset_busy", 32'(busy), 32'd0);
    exp_q.delete();
    set_score(4'd0, 4'd0);
    tick(3);
    reset = 1'b0;
    base = frames_seen;
    tick(50);
    chk("post_reset_silent", 32'(frames_seen), 32'(base));
    set_score(4'd6, 4'd1);
    exp_q.push_back(make_frame(8'h61));
    wait_frames(base + 1, 40);

    // Refresh instance with constant 99: starts exactly 20 cycles apart.
    r_starts.delete();
    tick(105);
    chk("refresh_count", 32'(r_starts.size() >= 5), 32'd1);
    for (int i = 1; i < r_starts.size(); i++) begin
      chk("refresh_period", 32'(r_starts[i] - r_starts[i-1]), 32'd20);
    end

    tick(5);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
